rr_decode_arbiter: RTL

- Round-robin arbiter that shares one resource among 8 requesters.
- Tracks the current owner as a 3-bit index and drives the one-hot grant that the 3-to-8 decoder produces from that index.
- Sits in front of the shared decoder/datapath. The owner holds the grant until it signals done, drops its request, or hits a hold timeout.

---
 rtl/rr_decode_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters: registered 3-bit owner index plus its one-hot decode.
// One-cycle grant latency, one idle cycle between owners, optional hold timeout.
module rr_decode_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
  // With the timeout disabled the counter just parks at its ceiling.
  localparam logic [7:0] HOLD_SAT = (MAX_HOLD == 0) ? 8'hFF : HOLD_MAX;

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic       grant_valid_q, grant_valid_d;
  logic       timeout_q, timeout_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       owner_req;
  logic       hold_expired;

  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req    = req[grant_idx_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    ptr_d         = ptr_q;
    hold_d        = hold_q;
    case (state_q)
      IDLE: begin
        if (en && win_found) begin
          state_d       = BUSY;
          grant_idx_d   = win_idx;
          grant_d       = 8'(1) << win_idx;
          grant_valid_d = 1'b1;
          hold_d        = 8'd1;
        end
      end
      BUSY: begin
        if (done || !owner_req || hold_expired) begin
          state_d       = IDLE;
          grant_d       = 8'h00;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 3'd1;
          timeout_d     = !done && owner_req;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 8'h00;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ptr_q         <= 3'd0;
      hold_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule
